// File: rtl/demux_8_16.sv
// demux_8_16 -- registered 1-to-8 demultiplexer for 16-bit words.
// One producer stream (in_valid/in_ready, in_data, in_sel) is steered into
// eight single-entry output channels, each with its own valid/ready pair.
// Configuration macro: DEMUX_HOLD_EN
//   defined   : y_k shows the channel register directly (holds last word).
//   undefined : y_k reads 16'h0000 whenever channel k is empty.
module demux_8_16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   input  logic [2:0]  in_sel,
   output logic [15:0] y0,
   output logic [15:0] y1,
   output logic [15:0] y2,
   output logic [15:0] y3,
   output logic [15:0] y4,
   output logic [15:0] y5,
   output logic [15:0] y6,
   output logic [15:0] y7,
   output logic [7:0]  out_valid,
   input  logic [7:0]  out_ready,
   output logic        busy
);

   logic [7:0]  full_reg;
   logic [15:0] y_arr [8];
   logic        acc;

   // A channel can take a word when it is empty or is being drained this
   // cycle; only the selected channel matters, in_valid is not involved.
   assign in_ready = ~full_reg[in_sel] | out_ready[in_sel];
   assign acc      = in_valid & in_ready;

   assign out_valid = full_reg;
   assign busy      = |full_reg;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_chan
         logic [15:0] data_reg;
         logic        full_q;
         logic        load;
         logic        drain;

         assign load  = acc & (in_sel == 3'(gi));
         assign drain = full_q & out_ready[gi];

         // Channel register: refill wins over drain so a simultaneous
         // drain+refill keeps the flag set with no bubble.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               data_reg <= 16'h0000;
               full_q   <= 1'b0;
            end else if (load) begin
               data_reg <= in_data;
               full_q   <= 1'b1;
            end else if (drain) begin
               full_q   <= 1'b0;
            end
         end

         assign full_reg[gi] = full_q;

`ifdef DEMUX_HOLD_EN
         assign y_arr[gi] = data_reg;
`else
         // Mask on the output only; the register keeps its contents.
         assign y_arr[gi] = full_q ? data_reg : 16'h0000;
`endif
      end
   endgenerate

   assign y0 = y_arr[0];
   assign y1 = y_arr[1];
   assign y2 = y_arr[2];
   assign y3 = y_arr[3];
   assign y4 = y_arr[4];
   assign y5 = y_arr[5];
   assign y6 = y_arr[6];
   assign y7 = y_arr[7];

endmodule

// File: tb/tb_demux_8_16.sv
// tb_demux_8_16 -- scoreboard bench for demux_8_16.
// Accepted words are pushed into a queue; each negedge the expected channel
// state is derived from the queue and compared with the DUT outputs.
// Honours DEMUX_HOLD_EN the same way as the design.
module tb_demux_8_16;

`ifdef DEMUX_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   typedef struct packed {
      logic [2:0]  sel;
      logic [15:0] data;
   } item_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [2:0]  in_sel;
   logic [15:0] y [8];
   logic [7:0]  out_valid;
   logic [7:0]  out_ready;
   logic        busy;

   item_t       sb [$];
   logic [15:0] last_data [8];
   int          n_checks = 0;
   int          n_fail   = 0;

   demux_8_16 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .y0        (y[0]),
      .y1        (y[1]),
      .y2        (y[2]),
      .y3        (y[3]),
      .y4        (y[4]),
      .y5        (y[5]),
      .y6        (y[6]),
      .y7        (y[7]),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int find_idx(input logic [2:0] ch);
      for (int i = 0; i < sb.size(); i++)
         if (sb[i].sel == ch) return i;
      return -1;
   endfunction

   // Held words vanish the moment reset is asserted.
   always @(negedge rst_n) begin
      sb.delete();
      for (int k = 0; k < 8; k++) last_data[k] = 16'h0000;
   end

   // Monitor: compare DUT against the scoreboard, then retire drains and
   // record accepts that will take effect at the next rising edge.
   always @(negedge clk) begin : monitor
      logic [7:0]  ev;
      logic        exp_rdy;
      logic [15:0] exp_y;
      int          idx;
      if (rst_n) begin
         ev = 8'h00;
         for (int i = 0; i < sb.size(); i++) ev[sb[i].sel] = 1'b1;
         exp_rdy = ~ev[in_sel] | out_ready[in_sel];
         check_val("out_valid", {24'h0, out_valid}, {24'h0, ev});
         check_val("busy", {31'h0, busy}, {31'h0, |ev});
         check_val("in_ready", {31'h0, in_ready}, {31'h0, exp_rdy});
         for (int k = 0; k < 8; k++) begin
            idx = find_idx(3'(k));
            if (HOLD)         exp_y = last_data[k];
            else if (ev[k])   exp_y = sb[idx].data;
            else              exp_y = 16'h0000;
            check_val($sformatf("y%0d", k), {16'h0, y[k]}, {16'h0, exp_y});
         end
         for (int k = 0; k < 8; k++) begin
            if (ev[k] && out_ready[k]) begin
               idx = find_idx(3'(k));
               $display("txn drain ch%0d data %h", k, sb[idx].data);
               sb.delete(idx);
            end
         end
         if (in_valid && exp_rdy) begin
            sb.push_back('{sel: in_sel, data: in_data});
            last_data[in_sel] = in_data;
            $display("txn accept ch%0d data %h", in_sel, in_data);
         end
      end
   end

   // Drive one cycle of input, returning 1 time unit after the rising edge.
   task automatic drive(input logic v, input logic [2:0] s, input logic [15:0] d);
      in_valid = v;
      in_sel   = s;
      in_data  = d;
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sel    = 3'd0;
      in_data   = 16'h0000;
      out_ready = 8'hFF;
      #1;
      check_val("rst_out_valid", {24'h0, out_valid}, 32'h0);
      check_val("rst_busy", {31'h0, busy}, 32'h0);
      check_val("rst_in_ready", {31'h0, in_ready}, 32'h1);
      check_val("rst_y0", {16'h0, y[0]}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Fan-out sweep: one word per cycle, each drained on the next edge.
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 3'(k), 16'hA000 + 16'(k));
         check_val($sformatf("sweep_y%0d", k), {16'h0, y[k]}, {16'h0, 16'hA000 + 16'(k)});
         check_val($sformatf("sweep_v%0d", k), {31'h0, out_valid[k]}, 32'h1);
      end
      drive(1'b0, 3'd0, 16'h0000);
      drive(1'b0, 3'd0, 16'h0000);

      // Back-pressure on channel 3.
      out_ready[3] = 1'b0;
      drive(1'b1, 3'd3, 16'h1234);
      check_val("bp_y3_first", {16'h0, y[3]}, 32'h1234);
      in_data = 16'h5678;
      #1;
      check_val("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
      drive(1'b1, 3'd3, 16'h5678);
      check_val("bp_y3_held", {16'h0, y[3]}, 32'h1234);
      out_ready[3] = 1'b1;
      drive(1'b1, 3'd3, 16'h5678);
      check_val("bp_y3_refill", {16'h0, y[3]}, 32'h5678);
      check_val("bp_v3_kept", {31'h0, out_valid[3]}, 32'h1);
      drive(1'b0, 3'd0, 16'h0000);

      // Isolation: channel 6 stalled while channel 1 is served.
      out_ready[6] = 1'b0;
      drive(1'b1, 3'd6, 16'h6666);
      drive(1'b1, 3'd1, 16'hBEEF);
      check_val("iso_y1", {16'h0, y[1]}, 32'hBEEF);
      check_val("iso_y6", {16'h0, y[6]}, 32'h6666);
      check_val("iso_v6", {31'h0, out_valid[6]}, 32'h1);
      out_ready[6] = 1'b1;
      drive(1'b0, 3'd0, 16'h0000);
      drive(1'b0, 3'd0, 16'h0000);

      // Idle inputs: nothing should happen.
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 3'($urandom_range(7)), 16'($urandom));
         check_val("idle_busy", {31'h0, busy}, 32'h0);
      end

      // Macro check: deliver then drain on channel 0.
      drive(1'b1, 3'd0, 16'hCAFE);
      drive(1'b0, 3'd0, 16'h0000);
      check_val("hold_v0", {31'h0, out_valid[0]}, 32'h0);
      check_val("hold_y0", {16'h0, y[0]}, HOLD ? 32'hCAFE : 32'h0);

      // Asynchronous reset mid-cycle with channels 2 and 5 full.
      out_ready[2] = 1'b0;
      out_ready[5] = 1'b0;
      drive(1'b1, 3'd2, 16'h2222);
      drive(1'b1, 3'd5, 16'h5555);
      drive(1'b0, 3'd5, 16'h0000);
      check_val("pre_rst_valid", {24'h0, out_valid}, 32'h24);
      #1;
      rst_n = 1'b0;
      #1;
      check_val("arst_out_valid", {24'h0, out_valid}, 32'h0);
      check_val("arst_y2", {16'h0, y[2]}, 32'h0);
      check_val("arst_y5", {16'h0, y[5]}, 32'h0);
      check_val("arst_in_ready", {31'h0, in_ready}, 32'h1);
      check_val("arst_busy", {31'h0, busy}, 32'h0);
      @(posedge clk); #1;
      rst_n     = 1'b1;
      out_ready = 8'hFF;
      drive(1'b1, 3'd5, 16'h0505);
      check_val("post_rst_y5", {16'h0, y[5]}, 32'h0505);
      drive(1'b0, 3'd0, 16'h0000);
      drive(1'b0, 3'd0, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
